// File: rtl/store_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_pkg
//  Description : Shared types and helpers for the narrow-store engine:
//                access-size encodings, FSM state enum, lane masks and the
//                big-endian lane placement / alignment helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package store_pkg;

    // Access size as presented on st_size.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        ERR   = 3'd4
    } state_e;

    // Unshifted lane masks; lane_shift() moves them into position.
    localparam logic [31:0] BYTE_LANE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_LANE_MASK = 32'h0000_FFFF;
    localparam logic [31:0] WORD_LANE_MASK = 32'hFFFF_FFFF;
    localparam logic [31:0] NONE_LANE_MASK = 32'h0000_0000;

    // Big-endian lane placement: byte k lives at [31-8k:24-8k], the half at
    // offset 0 lives in the upper 16 bits, the half at offset 2 in the lower.
    function automatic logic [4:0] lane_shift(input size_e sz, input logic [1:0] off);
        logic [1:0] inv;
        inv = 2'd3 - off;
        case (sz)
            SZ_BYTE: lane_shift = {inv, 3'b000};
            SZ_HALF: lane_shift = off[1] ? 5'd0 : 5'd16;
            default: lane_shift = 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] lane_mask(input size_e sz);
        case (sz)
            SZ_BYTE: lane_mask = BYTE_LANE_MASK;
            SZ_HALF: lane_mask = HALF_LANE_MASK;
            SZ_WORD: lane_mask = WORD_LANE_MASK;
            default: lane_mask = NONE_LANE_MASK;
        endcase
    endfunction

    // Reserved size is always rejected; halves need even, words need
    // word-aligned addresses.
    function automatic logic is_misaligned(input size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = off[0];
            SZ_WORD: is_misaligned = (off != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

endpackage : store_pkg
`default_nettype wire

// File: rtl/store_narrow_lane_merge.sv
`default_nettype none
// ============================================================================
//  Module      : lane_merge
//  Description : Combinational lane insert. Places the low-order bits of the
//                new data into the addressed big-endian lane of the old word
//                and keeps every other bit of the old word.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_merge
    import store_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] new_data_i,
    input  size_e       size_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] merged_o
);

    logic [4:0]  shift;
    logic [31:0] mask;

    // Position the lane mask and data, then splice into the old word.
    always_comb begin
        shift    = lane_shift(size_i, offset_i);
        mask     = lane_mask(size_i) << shift;
        merged_o = (old_word_i & ~mask) | ((new_data_i << shift) & mask);
    end

endmodule : lane_merge
`default_nettype wire

// File: rtl/store_narrow.sv
`default_nettype none
// ============================================================================
//  Module      : store_narrow
//  Description : Byte/half/word store engine in front of a word-only data
//                memory. Sub-word stores do a read-merge-write; word stores
//                write directly; misaligned/reserved requests are rejected.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_narrow
    import store_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          st_req,
    input  logic [AW-1:0] st_addr,
    input  logic [31:0]   st_data,
    input  logic [1:0]    st_size,
    output logic          st_busy,
    output logic          st_ack,
    output logic          st_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [31:0]   mem_rdata,
    output logic          mem_wr,
    output logic [31:0]   mem_wdata
);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q,  addr_d;
    logic [31:0]   data_q,  data_d;
    size_e         size_q,  size_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          in_idle;
    size_e         req_size;
    logic [31:0]   merge_old;
    logic [31:0]   merge_new;
    size_e         merge_size;
    logic [1:0]    merge_off;
    logic [31:0]   merged;

    // One merge unit serves both paths: in IDLE it builds the full word for
    // a word store straight from the request; in MERGE it splices the latched
    // sub-word data into the word just read back.
    always_comb begin
        in_idle    = (state_q == IDLE);
        req_size   = size_e'(st_size);
        merge_old  = (state_q == MERGE) ? mem_rdata : 32'h0;
        merge_new  = in_idle ? st_data        : data_q;
        merge_size = in_idle ? req_size       : size_q;
        merge_off  = in_idle ? st_addr[1:0]   : addr_q[1:0];
    end

    lane_merge u_lane_merge (
        .old_word_i (merge_old),
        .new_data_i (merge_new),
        .size_i     (merge_size),
        .offset_i   (merge_off),
        .merged_o   (merged)
    );

    // State and request registers; reset drops any store in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= 32'h0;
            size_q  <= SZ_BYTE;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (st_req) begin
                    addr_d = st_addr;
                    data_d = st_data;
                    size_d = req_size;
                    if (is_misaligned(req_size, st_addr[1:0])) begin
                        state_d = ERR;
                    end else if (req_size == SZ_WORD) begin
                        wdata_d = merged;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                state_d = MERGE;
            end
            MERGE: begin
                wdata_d = merged;
                state_d = WRITE;
            end
            WRITE: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode purely from state, so reset forces them all low at once.
    always_comb begin
        st_busy   = (state_q != IDLE);
        mem_rd    = (state_q == READ);
        mem_wr    = (state_q == WRITE);
        st_ack    = (state_q == WRITE);
        st_err    = (state_q == ERR);
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if ((state_q == READ) || (state_q == WRITE)) begin
            mem_addr = {addr_q[AW-1:2], 2'b00};
        end
        if (state_q == WRITE) begin
            mem_wdata = wdata_q;
        end
    end

endmodule : store_narrow
`default_nettype wire

// File: tb/tb_store_narrow.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_narrow
//  Description : Scoreboard bench for store_narrow. Stimulus pushes the
//                expected memory/handshake events; a monitor pops and
//                compares whenever the DUT raises a strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_narrow;

    localparam int AW = 32;
    localparam int EV_RD  = 0;
    localparam int EV_WR  = 1;
    localparam int EV_ERR = 2;
    localparam int K_WORD   = 0;
    localparam int K_NARROW = 1;
    localparam int K_ERR    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          st_req;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [1:0]    st_size;
    logic          st_busy;
    logic          st_ack;
    logic          st_err;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [31:0]   mem_rdata;
    logic          mem_wr;
    logic [31:0]   mem_wdata;

    logic [31:0]   next_rdata;
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];

    store_narrow #(.AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_req    (st_req),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_size   (st_size),
        .st_busy   (st_busy),
        .st_ack    (st_ack),
        .st_err    (st_err),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Word memory: read data appears exactly one cycle after mem_rd,
    // otherwise a poison pattern.
    always @(posedge clk) mem_rdata <= mem_rd ? next_rdata : 32'hA5A5_A5A5;

    function automatic void push_ev(input int kind, input int c, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic monitor_loop();
        ev_t e;
        int  kind;
        logic ok;
        forever begin
            @(negedge clk);
            if (rst_n && (mem_rd || mem_wr || st_ack || st_err)) begin
                checks++;
                kind = mem_rd ? EV_RD : (st_err ? EV_ERR : EV_WR);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: rd=%b wr=%b ack=%b err=%b at cyc %0d, required no strobe",
                             mem_rd, mem_wr, st_ack, st_err, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (kind == e.kind) && (cyc == e.cyc) && (mem_wr == st_ack)
                         && ($countones({mem_rd, mem_wr, st_err}) == 1);
                    if (e.kind != EV_ERR) ok = ok && (mem_addr == e.addr);
                    if (e.kind == EV_WR)  ok = ok && (mem_wdata == e.data);
                    if (!ok) begin
                        errors++;
                        $display("FAIL event: got kind=%0d cyc=%0d rd=%b wr=%b ack=%b err=%b addr=%h wdata=%h, required kind=%0d cyc=%0d addr=%h wdata=%h",
                                 kind, cyc, mem_rd, mem_wr, st_ack, st_err, mem_addr, mem_wdata,
                                 e.kind, e.cyc, e.addr, e.data);
                    end
                end
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (st_busy || st_ack || st_err || mem_rd || mem_wr || (mem_addr != '0) || (mem_wdata != 32'h0)) begin
            errors++;
            $display("FAIL %s: busy=%b ack=%b err=%b rd=%b wr=%b addr=%h wdata=%h, required all 0",
                     name, st_busy, st_ack, st_err, mem_rd, mem_wr, mem_addr, mem_wdata);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (st_busy && (n < 10)) begin
            @(negedge clk);
            n++;
        end
        if (st_busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: st_busy=%b after %0d cycles, required 0", st_busy, n);
        end
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                            input logic [31:0] rd, input int kind, input logic [31:0] exp_w);
        int m;
        @(negedge clk);
        st_addr    = a;
        st_data    = d;
        st_size    = sz;
        next_rdata = rd;
        st_req     = 1'b1;
        m          = cyc;
        case (kind)
            K_WORD:   push_ev(EV_WR, m + 1, {a[31:2], 2'b00}, exp_w);
            K_NARROW: begin
                push_ev(EV_RD, m + 1, {a[31:2], 2'b00}, 32'h0);
                push_ev(EV_WR, m + 3, {a[31:2], 2'b00}, exp_w);
            end
            default:  push_ev(EV_ERR, m + 1, 32'h0, 32'h0);
        endcase
        @(negedge clk);
        st_req = 1'b0;
        checks++;
        if (!st_busy) begin
            errors++;
            $display("FAIL busy_after_req: st_busy=%b, required 1", st_busy);
        end
        wait_idle();
    endtask

    initial begin
        int m;
        rst_n      = 1'b0;
        st_req     = 1'b0;
        st_addr    = '0;
        st_data    = 32'h0;
        st_size    = 2'b00;
        next_rdata = 32'h0;
        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Word, byte, half stores with hand-computed merged words.
        do_store(32'h100, 32'hDEAD_BEEF, 2'b10, 32'h0,         K_WORD,   32'hDEAD_BEEF);
        do_store(32'h203, 32'h1234_56AB, 2'b00, 32'h1122_3344, K_NARROW, 32'h1122_33AB);
        do_store(32'h302, 32'hFFFF_CAFE, 2'b01, 32'h0000_0000, K_NARROW, 32'h0000_CAFE);
        do_store(32'h300, 32'hFFFF_CAFE, 2'b01, 32'h0000_0000, K_NARROW, 32'hCAFE_0000);
        do_store(32'h200, 32'h0000_00EE, 2'b00, 32'h1122_3344, K_NARROW, 32'hEE22_3344);
        do_store(32'h201, 32'hFFFF_FFEE, 2'b00, 32'h1122_3344, K_NARROW, 32'h11EE_3344);
        do_store(32'h402, 32'h0000_BEEF, 2'b01, 32'hAAAA_5555, K_NARROW, 32'hAAAA_BEEF);

        // Rejected requests.
        do_store(32'h301, 32'h0000_1234, 2'b01, 32'h0, K_ERR, 32'h0);
        do_store(32'h102, 32'h1234_5678, 2'b10, 32'h0, K_ERR, 32'h0);
        do_store(32'h100, 32'h1234_5678, 2'b11, 32'h0, K_ERR, 32'h0);

        // st_req held high: one byte store, then a word store accepted in the
        // first IDLE cycle after st_ack.
        @(negedge clk);
        st_addr    = 32'h203;
        st_data    = 32'h0000_00C3;
        st_size    = 2'b00;
        next_rdata = 32'hAABB_CCDD;
        st_req     = 1'b1;
        m          = cyc;
        push_ev(EV_RD, m + 1, 32'h200, 32'h0);
        push_ev(EV_WR, m + 3, 32'h200, 32'hAABB_CCC3);
        push_ev(EV_WR, m + 5, 32'h500, 32'h5566_7788);
        repeat (3) @(negedge clk);
        st_addr = 32'h500;
        st_data = 32'h5566_7788;
        st_size = 2'b10;
        repeat (2) @(negedge clk);
        st_req = 1'b0;
        wait_idle();

        // Reset asserted during MERGE: outputs drop immediately, no write.
        repeat (2) @(negedge clk);
        st_addr    = 32'h601;
        st_data    = 32'h0000_0077;
        st_size    = 2'b00;
        next_rdata = 32'h1234_5678;
        st_req     = 1'b1;
        m          = cyc;
        push_ev(EV_RD, m + 1, 32'h600, 32'h0);
        @(negedge clk);
        st_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_merge");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        do_store(32'h400, 32'h0102_0304, 2'b10, 32'h0, K_WORD, 32'h0102_0304);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL events_pending: %0d expected events never seen, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_store_narrow
`default_nettype wire

// File: doc/store_narrow.md
STORE_NARROW -- requirements
Module: store_narrow

Interface
REQ-001 SHALL have parameter AW, default 32: byte-address width of st_addr and mem_addr.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port st_req, input, 1: store request, sampled only in IDLE.
REQ-005 SHALL have port st_addr, input, AW: byte address of the store.
REQ-006 SHALL have port st_data, input, 32: register value to store, low-order bits used for sub-word stores.
REQ-007 SHALL have port st_size, input, 2: 00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port st_busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port st_ack, output, 1: one-cycle pulse on completion of a store.
REQ-010 SHALL have port st_err, output, 1: one-cycle pulse on a rejected request.
REQ-011 SHALL have port mem_addr, output, AW: word address, bits [1:0] always 0.
REQ-012 SHALL have port mem_rd, output, 1: word read strobe; mem_rdata is valid exactly one cycle later.
REQ-013 SHALL have port mem_rdata, input, 32: read data from the word-only data memory.
REQ-014 SHALL have port mem_wr, output, 1: word write strobe.
REQ-015 SHALL have port mem_wdata, output, 32: full word to write.

Function
REQ-016 SHALL implement FSM states IDLE, READ, MERGE, WRITE, ERR.
REQ-017 SHALL, in IDLE with st_req=1, latch st_addr, st_data and st_size, then go to ERR when misaligned, to WRITE for word, or to READ for byte/half.
REQ-018 SHALL treat as misaligned: size 11; half with addr[0]=1; word with addr[1:0]!=00.
REQ-019 SHALL, in ERR, pulse st_err for one cycle, issue no mem_rd/mem_wr, and return to IDLE.
REQ-020 SHALL, in READ, assert mem_rd for one cycle with mem_addr={addr[AW-1:2],2'b00}.
REQ-021 SHALL, in MERGE, register mem_rdata with the narrowed store data replacing the addressed lane, leaving all other bits unchanged.
REQ-022 SHALL use big-endian lanes: byte offset k occupies bits [31-8k:24-8k]; half at addr[1]=0 occupies [31:16], at addr[1]=1 occupies [15:0].
REQ-023 SHALL source byte data from st_data[7:0], half from st_data[15:0], word from st_data[31:0], discarding the upper bits (no extension).
REQ-024 SHALL, in WRITE, assert mem_wr and st_ack together for exactly one cycle, then return to IDLE.
REQ-025 SHALL have latency from request cycle to st_ack: word 1 cycle, byte/half 3 cycles, error 1 cycle (st_err instead of st_ack).
REQ-026 SHALL ignore st_req whenever st_busy=1; the earliest next acceptance is the first cycle back in IDLE (the cycle after st_ack/st_err).
REQ-027 SHALL hold mem_rd, mem_wr, st_ack and st_err low in every state other than the one named for each.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE and drive st_busy, st_ack, st_err, mem_rd, mem_wr, mem_addr and mem_wdata to 0.
REQ-029 SHALL drop any in-flight store when reset is asserted mid-operation, with no mem_wr issued after reset release.

Structure
REQ-030 SHALL take size encodings, the FSM state enum and lane-select constants from shared package store_pkg.
REQ-031 SHALL instantiate one combinational sub-module, lane_merge (inputs: old word, new data, size, offset; output: merged word), reused for the word case.

Verification
REQ-032 SHALL cover: word store, addr 0x100, data 0xDEADBEEF -> mem_wr one cycle later with mem_addr 0x100, mem_wdata 0xDEADBEEF, st_ack coincident.
REQ-033 SHALL cover: byte store, addr 0x203, data 0x123456AB, mem_rdata 0x11223344 -> mem_rd at +1, mem_wr at +3 with mem_wdata 0x112233AB.
REQ-034 SHALL cover: half store, addr 0x302, data 0xFFFFCAFE, mem_rdata 0x00000000 -> mem_wdata 0x0000CAFE; the same at addr 0x300 -> 0xCAFE0000.
REQ-035 SHALL cover: half at 0x301, word at 0x102, and size 11 -> st_err pulse at +1, no mem_rd/mem_wr, back to IDLE.
REQ-036 SHALL cover: st_req held high across a byte store -> exactly one store executed before acknowledgement, and a second accepted in the first cycle after st_ack.
REQ-037 SHALL cover: rst_n pulsed low during MERGE -> all outputs 0 at once, no mem_wr afterwards, and a new request accepted normally after release.
